iter_alu: RTL
=============

ITER_ALU -- requirements
Module: iter_alu

Interface
REQ-001 clk  input  1  rising-edge clock.
REQ-002 reset  input  1  reset, asynchronous, active-low.
REQ-003 start  input  1  one-cycle request; sampled only in IDLE.
REQ-004 alu_op  input  3  0 ADD, 1 SUB, 2 MULT, 3 NAND, 4 DIV, 5 MOD, 6 LT, 7 LTE.
REQ-005 im_en  input  1  selects immediate as operand Y.
REQ-006 im  input  4  immediate field, zero-extended to 16 bits.
REQ-007 reg_a  input  16  register port A (operand Y when im_en=0).
REQ-008 reg_b  input  16  register port B (operand X, always).
REQ-009 busy  output  1  high in CALC and DONE.
REQ-010 done  output  1  one-cycle pulse; result valid.
REQ-011 result  output  16  registered result.
REQ-012 alu_status  output  16  registered copy of result for branch decisions.
REQ-013 div_by_zero  output  1  high with done when DIV/MOD had Y=0.

Function
REQ-014 X=reg_b, Y=im_en?{12'b0,im}:reg_a; all operands and im_en captured at start accept and held internally.
REQ-015 Operations unsigned, 16-bit wrap: ADD X+Y; SUB X-Y; MULT low 16 bits of X*Y; NAND ~(X&Y); DIV X/Y; MOD X%Y; LT (X<Y)?1:0; LTE (X<=Y)?1:0.
REQ-016 States IDLE, CALC, DONE; IDLE->CALC on start with op MULT/DIV/MOD and nonzero divisor; IDLE->DONE on start otherwise; CALC->DONE after 16 iterations; DONE->IDLE unconditionally.
REQ-017 Latency: start accepted at edge k; single-cycle ops and divide-by-zero assert done in cycle after edge k; MULT/DIV/MOD assert done after edge k+16 (17 cycles from start to done).
REQ-018 MULT: shift-add, one multiplicand bit per CALC cycle, LSB first, 16-bit accumulator (upper bits discarded).
REQ-019 DIV/MOD: restoring division, one quotient bit per CALC cycle, MSB first; DIV returns quotient, MOD remainder.
REQ-020 Y=0 on DIV: result 16'hFFFF; on MOD: result X; div_by_zero=1 for that done pulse only.
REQ-021 done high exactly one cycle (DONE state); result/alu_status update on entry to DONE and hold until next DONE.
REQ-022 start while busy ignored, no effect on in-flight operation or outputs.
REQ-023 Changes on reg_a/reg_b/im/alu_op during CALC do not affect result.
REQ-024 Next start accepted earliest in IDLE cycle after DONE (minimum 2-cycle issue interval).

Reset
REQ-025 reset low forces state IDLE, busy=0, done=0, result=16'h0000, alu_status=16'h0000, div_by_zero=0, iteration counter 0, irrespective of clk.
REQ-026 reset mid-CALC aborts operation; no done pulse produced; first start after release accepted normally.

Structure
REQ-027 Shared package alu_pkg holds op-code constants (ALU_ADD..ALU_LTE), DATA_W=16, ITER_CNT=16, state encoding.
REQ-028 One sub-module iter_divider (restoring divide, start/done, quotient and remainder) instantiated inside iter_alu; multiplier and single-cycle ops inline.

Verification
REQ-029 ADD X=16'h7FFF, Y=16'h0001, im_en=0 -> result 16'h8000, done one cycle after start, busy low after.
REQ-030 SUB im_en=1 im=4'h5, X=16'h0003 -> result 16'hFFFE; LT same operands -> 16'h0001; LTE X=Y=16'h0009 -> 16'h0001.
REQ-031 MULT X=16'h0123, Y=16'h0100 -> result 16'h2300 at done 17 cycles after start; start pulsed mid-CALC ignored.
REQ-032 DIV X=16'd1000, Y=16'd7 -> 16'd142; MOD same -> 16'd6; each 17-cycle latency, div_by_zero=0.
REQ-033 DIV X=16'h1234, Y=0 -> 16'hFFFF, div_by_zero=1, 1-cycle latency; MOD same -> 16'h1234.
REQ-034 reset asserted at CALC cycle 8 of DIV -> all outputs zero immediately, no done; post-release NAND X=16'hFF00,Y=16'h0FF0 -> 16'hF0FF.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the iterative ALU: data width, iteration count,
// op-code constants, FSM state encoding and the single-cycle op evaluator.
package alu_pkg;

  localparam int DATA_W   = 16;
  localparam int ITER_CNT = 16;
  localparam int CNT_W    = $clog2(ITER_CNT);

  localparam logic [2:0] ALU_ADD  = 3'd0;
  localparam logic [2:0] ALU_SUB  = 3'd1;
  localparam logic [2:0] ALU_MULT = 3'd2;
  localparam logic [2:0] ALU_NAND = 3'd3;
  localparam logic [2:0] ALU_DIV  = 3'd4;
  localparam logic [2:0] ALU_MOD  = 3'd5;
  localparam logic [2:0] ALU_LT   = 3'd6;
  localparam logic [2:0] ALU_LTE  = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } alu_state_t;

  // Result of every op that finishes without iterating. DIV/MOD only land
  // here with a zero divisor, so they return the divide-by-zero values.
  // MULT always iterates and never uses this path.
  function automatic logic [DATA_W-1:0] alu_single(input logic [2:0]        op,
                                                   input logic [DATA_W-1:0] x,
                                                   input logic [DATA_W-1:0] y);
    logic [DATA_W-1:0] r;
    r = '0;
    case (op)
      ALU_ADD:  r = x + y;
      ALU_SUB:  r = x - y;
      ALU_NAND: r = ~(x & y);
      ALU_DIV:  r = '1;
      ALU_MOD:  r = x;
      ALU_LT:   r = (x <  y) ? DATA_W'(1) : '0;
      ALU_LTE:  r = (x <= y) ? DATA_W'(1) : '0;
      default:  r = '0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/iter_divider.sv
// Restoring divider, one quotient bit per cycle, MSB first.
// Ports:
//   clk, reset     clock, asynchronous active-low reset
//   start          load dividend/divisor and begin ITER_CNT iterations
//   dividend       numerator
//   divisor        denominator (caller guarantees nonzero)
//   done           high during the final iteration cycle
//   quotient       quotient, valid while done is high
//   remainder      remainder, valid while done is high
module iter_divider
  import alu_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [DATA_W-1:0] dividend,
  input  logic [DATA_W-1:0] divisor,
  output logic              done,
  output logic [DATA_W-1:0] quotient,
  output logic [DATA_W-1:0] remainder
);

  logic [DATA_W-1:0] dvd_q, dvs_q, rem_q, quo_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              running_q;

  logic [DATA_W:0]   shifted, diff;
  logic [DATA_W-1:0] rem_next, quo_next;

  // One restoring step. Bit DATA_W of diff is the borrow: set means the
  // trial subtraction went negative and the shifted remainder is kept.
  always_comb begin
    shifted = {rem_q, dvd_q[DATA_W-1]};
    diff    = shifted - {1'b0, dvs_q};
    if (diff[DATA_W]) begin
      rem_next = shifted[DATA_W-1:0];
      quo_next = {quo_q[DATA_W-2:0], 1'b0};
    end else begin
      rem_next = diff[DATA_W-1:0];
      quo_next = {quo_q[DATA_W-2:0], 1'b1};
    end
  end

  // Outputs expose the step being computed now, so the caller can register
  // the final values on the same edge that completes the last iteration.
  assign done      = running_q && (cnt_q == CNT_W'(ITER_CNT - 1));
  assign quotient  = quo_next;
  assign remainder = rem_next;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dvd_q     <= '0;
      dvs_q     <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      cnt_q     <= '0;
      running_q <= 1'b0;
    end else if (start) begin
      dvd_q     <= dividend;
      dvs_q     <= divisor;
      rem_q     <= '0;
      quo_q     <= '0;
      cnt_q     <= '0;
      running_q <= 1'b1;
    end else if (running_q) begin
      dvd_q <= dvd_q << 1;
      rem_q <= rem_next;
      quo_q <= quo_next;
      cnt_q <= cnt_q + 1'b1;
      if (done) running_q <= 1'b0;
    end
  end

endmodule

// File: rtl/iter_alu.sv
// Iterative 16-bit ALU: single-cycle ADD/SUB/NAND/LT/LTE, 16-cycle
// shift-add MULT and restoring DIV/MOD.
// Ports:
//   clk, reset   clock, asynchronous active-low reset
//   start        request, sampled only in IDLE
//   alu_op       operation select
//   im_en, im    use zero-extended immediate as operand Y
//   reg_a        operand Y when im_en=0
//   reg_b        operand X
//   busy         high in CALC and DONE
//   done         one-cycle result-valid pulse
//   result       registered result
//   alu_status   registered copy of result
//   div_by_zero  high with done when DIV/MOD saw Y=0
module iter_alu
  import alu_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [2:0]        alu_op,
  input  logic              im_en,
  input  logic [3:0]        im,
  input  logic [DATA_W-1:0] reg_a,
  input  logic [DATA_W-1:0] reg_b,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] result,
  output logic [DATA_W-1:0] alu_status,
  output logic              div_by_zero
);

  alu_state_t state_q, state_d;

  logic [2:0]        op_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [DATA_W-1:0] acc_q, mcand_q, mplier_q, acc_next;
  logic [DATA_W-1:0] y_sel, single_res, calc_res;
  logic              dbz_q;
  logic              accept, is_divmod, is_iter, calc_last;
  logic              div_done;
  logic [DATA_W-1:0] div_quo, div_rem;

  assign y_sel      = im_en ? {{(DATA_W-4){1'b0}}, im} : reg_a;
  assign accept     = (state_q == ST_IDLE) && start;
  assign is_divmod  = (alu_op == ALU_DIV) || (alu_op == ALU_MOD);
  assign is_iter    = (alu_op == ALU_MULT) || (is_divmod && (y_sel != '0));
  assign single_res = alu_single(alu_op, reg_b, y_sel);

  // Shift-add multiply: multiplier bits consumed LSB first, accumulator
  // keeps only the low DATA_W bits.
  assign acc_next  = acc_q + (mplier_q[0] ? mcand_q : '0);
  assign calc_last = (op_q == ALU_MULT) ? (cnt_q == CNT_W'(ITER_CNT - 1)) : div_done;
  assign calc_res  = (op_q == ALU_MULT) ? acc_next :
                     (op_q == ALU_DIV)  ? div_quo  : div_rem;

  iter_divider u_div (
    .clk       (clk),
    .reset     (reset),
    .start     (accept && is_iter && is_divmod),
    .dividend  (reg_b),
    .divisor   (y_sel),
    .done      (div_done),
    .quotient  (div_quo),
    .remainder (div_rem)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start) state_d = is_iter ? ST_CALC : ST_DONE;
      ST_CALC: if (calc_last) state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    busy        = (state_q != ST_IDLE);
    done        = (state_q == ST_DONE);
    div_by_zero = dbz_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      op_q       <= ALU_ADD;
      cnt_q      <= '0;
      acc_q      <= '0;
      mcand_q    <= '0;
      mplier_q   <= '0;
      result     <= '0;
      alu_status <= '0;
      dbz_q      <= 1'b0;
    end else if (accept) begin
      op_q     <= alu_op;
      cnt_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= reg_b;
      mplier_q <= y_sel;
      if (!is_iter) begin
        result     <= single_res;
        alu_status <= single_res;
        dbz_q      <= is_divmod;
      end
    end else if (state_q == ST_CALC) begin
      cnt_q    <= cnt_q + 1'b1;
      acc_q    <= acc_next;
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
      if (calc_last) begin
        result     <= calc_res;
        alu_status <= calc_res;
        dbz_q      <= 1'b0;
      end
    end else if (state_q == ST_DONE) begin
      dbz_q <= 1'b0;
    end
  end

endmodule
